// File: rtl/instruction_fetch.sv
// Instruction fetch stage: programmable instruction memory plus program counter,
// presenting one registered instruction per cycle to the control unit.
module instruction_fetch #(
  parameter int          INSTR_WIDTH = 16,
  parameter int          ADDR_WIDTH  = 8,
  parameter logic [2:0]  HALT_OPCODE = 3'b111
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   prog_we,
  input  logic [ADDR_WIDTH-1:0]  prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   stall,
  input  logic                   jump,
  input  logic [ADDR_WIDTH-1:0]  jump_target,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic [2:0]             control_opcode,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   halted,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t                 state, state_next;
  logic [ADDR_WIDTH-1:0]  pc, pc_next;
  logic [INSTR_WIDTH-1:0] instr_next;
  logic [ADDR_WIDTH-1:0]  instr_pc_next;
  logic                   valid_next;
  logic                   mem_we;

  // Memory has no reset so a loaded program survives reset.
  logic [INSTR_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (mem_we) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr       <= instr_next;
      instr_pc    <= instr_pc_next;
      instr_valid <= valid_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    instr_next    = instr;
    instr_pc_next = instr_pc;
    valid_next    = instr_valid;
    mem_we        = 1'b0;
    case (state)
      IDLE: begin
        mem_we = prog_we && !reset;
        if (start) begin
          state_next = FETCH;
          pc_next    = '0;
        end
      end
      FETCH: begin
        if (!stall) begin
          if (instr_valid && control_opcode == HALT_OPCODE) begin
            state_next = HALTED;
            valid_next = 1'b0;
          end else if (instr_valid && jump) begin
            // Squash the sequential word: one bubble, then fetch the target.
            pc_next    = jump_target;
            valid_next = 1'b0;
          end else begin
            instr_next    = mem[pc];
            instr_pc_next = pc;
            valid_next    = 1'b1;
            pc_next       = pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          end
        end
      end
      default: ;
    endcase
  end

  assign control_opcode = instr[INSTR_WIDTH-1 -: 3];
  assign busy           = (state == FETCH);
  assign halted         = (state == HALTED);
  assign dbg_state      = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch: a main instance with
// 8-bit addresses and a 3-bit-address instance for PC wrap-around.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        reset, start, prog_we, stall, jump;
  logic [7:0]  prog_addr, jump_target;
  logic [15:0] prog_data;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic [2:0]  control_opcode;
  logic        instr_valid, busy, halted;
  logic [1:0]  dbg_state;

  // wrap instance
  logic        w_reset, w_start, w_prog_we;
  logic [2:0]  w_prog_addr;
  logic [15:0] w_prog_data;
  logic [15:0] w_instr;
  logic [2:0]  w_instr_pc;
  logic [2:0]  w_control_opcode;
  logic        w_instr_valid, w_busy, w_halted;
  logic [1:0]  w_dbg_state;

  instruction_fetch #(.INSTR_WIDTH(16), .ADDR_WIDTH(8), .HALT_OPCODE(3'b111)) u_dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .stall(stall), .jump(jump),
    .jump_target(jump_target), .instr(instr), .instr_pc(instr_pc),
    .control_opcode(control_opcode), .instr_valid(instr_valid), .busy(busy),
    .halted(halted), .dbg_state(dbg_state)
  );

  instruction_fetch #(.INSTR_WIDTH(16), .ADDR_WIDTH(3), .HALT_OPCODE(3'b111)) u_wrap (
    .clk(clk), .reset(w_reset), .start(w_start), .prog_we(w_prog_we),
    .prog_addr(w_prog_addr), .prog_data(w_prog_data), .stall(1'b0), .jump(1'b0),
    .jump_target(3'd0), .instr(w_instr), .instr_pc(w_instr_pc),
    .control_opcode(w_control_opcode), .instr_valid(w_instr_valid), .busy(w_busy),
    .halted(w_halted), .dbg_state(w_dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        stall;
    logic        jump;
    logic [7:0]  target;
    logic        valid;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        halted;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic j, logic [7:0] t, logic v,
                              logic [7:0] p, logic [15:0] i, logic h);
    vec_t r;
    r.stall = s; r.jump = j; r.target = t; r.valid = v;
    r.pc = p; r.instr = i; r.halted = h;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic prog_write(input logic [7:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".instr"},    32'(instr), 32'h0);
    check({tag, ".instr_pc"}, 32'(instr_pc), 32'h0);
    check({tag, ".valid"},    32'(instr_valid), 32'h0);
    check({tag, ".opcode"},   32'(control_opcode), 32'h0);
    check({tag, ".busy"},     32'(busy), 32'h0);
    check({tag, ".halted"},   32'(halted), 32'h0);
  endtask

  // Apply every queued vector, one clock each, then empty the queue.
  task automatic run_vecs(input string tag);
    logic [15:0] exp_i;
    foreach (vecs[k]) begin
      stall = vecs[k].stall; jump = vecs[k].jump; jump_target = vecs[k].target;
      step();
      exp_i = vecs[k].instr;
      check($sformatf("%s[%0d].valid", tag, k),  32'(instr_valid), 32'(vecs[k].valid));
      check($sformatf("%s[%0d].pc", tag, k),     32'(instr_pc), 32'(vecs[k].pc));
      check($sformatf("%s[%0d].instr", tag, k),  32'(instr), 32'(exp_i));
      check($sformatf("%s[%0d].opcode", tag, k), 32'(control_opcode), 32'(exp_i[15:13]));
      check($sformatf("%s[%0d].halted", tag, k), 32'(halted), 32'(vecs[k].halted));
      check($sformatf("%s[%0d].busy", tag, k),   32'(busy), 32'(!vecs[k].halted));
    end
    stall = 1'b0; jump = 1'b0;
    vecs.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; prog_we = 1'b0; stall = 1'b0; jump = 1'b0;
    prog_addr = '0; jump_target = '0; prog_data = '0;
    w_reset = 1'b0; w_start = 1'b0; w_prog_we = 1'b0; w_prog_addr = '0; w_prog_data = '0;

    // Reset state
    do_reset();
    check_reset_outputs("reset");

    // Straight-line fetch to HALT
    prog_write(8'd0, 16'h8000);
    prog_write(8'd1, 16'hA001);
    prog_write(8'd2, 16'hC002);
    prog_write(8'd3, 16'hE000);
    pulse_start();
    check("start.busy", 32'(busy), 32'h1);
    check("start.valid", 32'(instr_valid), 32'h0);
    vecs.push_back(mk(0, 0, 0, 1, 8'd0, 16'h8000, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'd1, 16'hA001, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'd2, 16'hC002, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'd3, 16'hE000, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'd3, 16'hE000, 1));
    run_vecs("line");
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("halt_hold[%0d].halted", c), 32'(halted), 32'h1);
      check($sformatf("halt_hold[%0d].valid", c), 32'(instr_valid), 32'h0);
    end

    // Halt then start; programming attempts in HALTED are ignored
    pulse_start();
    check("halt_start.halted", 32'(halted), 32'h1);
    check("halt_start.busy", 32'(busy), 32'h0);
    check("halt_start.pc", 32'(instr_pc), 32'h3);
    prog_write(8'd0, 16'hFFFF);
    do_reset();
    check_reset_outputs("halt_reset");
    pulse_start();
    step();
    check("restart.valid", 32'(instr_valid), 32'h1);
    check("restart.pc", 32'(instr_pc), 32'h0);
    check("restart.instr", 32'(instr), 32'h8000);

    // Common program for jump / stall / reset tests
    do_reset();
    prog_write(8'd0, 16'h0000);
    prog_write(8'd1, 16'h2001);
    prog_write(8'd2, 16'h6000);
    prog_write(8'd3, 16'h4003);
    prog_write(8'd4, 16'hA004);
    prog_write(8'd5, 16'hC005);
    prog_write(8'd6, 16'hE000);
    prog_write(8'd9, 16'hE000);

    // Jump: ignored while no valid instruction, then one-bubble redirect
    pulse_start();
    vecs.push_back(mk(0, 1, 8'd9, 1, 8'd0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 8'd1, 16'h2001, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 8'd2, 16'h6000, 0));
    vecs.push_back(mk(0, 1, 8'd9, 0, 8'd2, 16'h6000, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 8'd9, 16'hE000, 0));
    vecs.push_back(mk(0, 0, 8'd0, 0, 8'd9, 16'hE000, 1));
    run_vecs("jump");

    // Stall at pc 1 for 3 cycles with jump held, then release
    do_reset();
    pulse_start();
    vecs.push_back(mk(0, 0, 8'd0, 1, 8'd0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 8'd1, 16'h2001, 0));
    vecs.push_back(mk(1, 1, 8'd9, 1, 8'd1, 16'h2001, 0));
    vecs.push_back(mk(1, 0, 8'd9, 1, 8'd1, 16'h2001, 0));
    vecs.push_back(mk(1, 1, 8'd9, 1, 8'd1, 16'h2001, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 8'd2, 16'h6000, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 8'd3, 16'h4003, 0));
    run_vecs("stall");

    // Reset mid-run with prog_we during FETCH and competing inputs at reset
    do_reset();
    pulse_start();
    step(); step(); step();
    prog_we = 1'b1; prog_addr = 8'd2; prog_data = 16'hFFFF;
    step();
    prog_we = 1'b0;
    step(); step();
    check("midrun.pc", 32'(instr_pc), 32'h5);
    check("midrun.instr", 32'(instr), 32'hC005);
    reset = 1'b1; stall = 1'b1; jump = 1'b1; jump_target = 8'd9; start = 1'b1;
    prog_we = 1'b1; prog_addr = 8'd0; prog_data = 16'hFFFF;
    step();
    reset = 1'b0; stall = 1'b0; jump = 1'b0; start = 1'b0; prog_we = 1'b0;
    check_reset_outputs("midrun_reset");
    step();
    check("midrun_idle.busy", 32'(busy), 32'h0);
    pulse_start();
    vecs.push_back(mk(0, 0, 8'd0, 1, 8'd0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 8'd1, 16'h2001, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 8'd2, 16'h6000, 0));
    run_vecs("rerun");

    // Wrap-around on the 3-bit-address instance
    w_reset = 1'b1;
    step();
    w_reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      w_prog_we = 1'b1; w_prog_addr = 3'(a); w_prog_data = 16'h1000 + 16'(a);
      step();
    end
    w_prog_we = 1'b0;
    w_start = 1'b1;
    step();
    w_start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("wrap[%0d].pc", c), 32'(w_instr_pc), 32'(c % 8));
      check($sformatf("wrap[%0d].instr", c), 32'(w_instr), 32'(16'h1000 + 16'(c % 8)));
      check($sformatf("wrap[%0d].valid", c), 32'(w_instr_valid), 32'h1);
    end
    check("wrap.halted", 32'(w_halted), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage directly upstream of the control unit. Holds a programmable instruction memory and the program counter. Each cycle it presents a registered instruction word, its address and a valid flag, and drives the 3-bit opcode field straight into the control unit's `control_opcode`. Jump redirects come back from the datapath, and a HALT opcode (3'b111) stops fetching.

## Interface
- `INSTR_WIDTH`, 16, instruction word width; opcode is `instr[INSTR_WIDTH-1 -: 3]`
- `ADDR_WIDTH`, 8, PC and memory address width; memory depth is 2^ADDR_WIDTH words
- `HALT_OPCODE`, 3'b111, opcode that stops fetching
- `clk` input 1: the single clock; all state changes on its rising edge
- `reset` input 1: synchronous, active-high
- `start` input 1: begin fetching at PC 0; honoured only in IDLE
- `prog_we` input 1: write enable for the instruction memory; honoured only in IDLE
- `prog_addr` input ADDR_WIDTH: write address
- `prog_data` input INSTR_WIDTH: write data
- `stall` input 1: freezes PC, outputs and state while high
- `jump` input 1: redirect request from the control unit for the current instruction
- `jump_target` input ADDR_WIDTH: redirect address
- `instr` output INSTR_WIDTH: registered instruction word
- `instr_pc` output ADDR_WIDTH: address `instr` was fetched from
- `control_opcode` output 3: `instr[INSTR_WIDTH-1 -: 3]`, combinational from `instr`
- `instr_valid` output 1: `instr` is a live instruction this cycle
- `busy` output 1: state is FETCH
- `halted` output 1: state is HALTED

## Operation
- **States:** IDLE, FETCH, HALTED. Reset forces IDLE from any state.
- **IDLE**
  - If `prog_we`: `mem[prog_addr] <= prog_data`.
  - If `start`: go to FETCH, `pc <= 0`.
  - `prog_we` and `start` in the same cycle: the write is performed and FETCH is entered.
- **FETCH, `stall` low, priority order:**
  1. `instr_valid && control_opcode == HALT_OPCODE`: go to HALTED, `instr_valid <= 0`, `pc` held.
  2. `instr_valid && jump`: `pc <= jump_target`, `instr_valid <= 0`. The sequential word is squashed, giving a one-bubble redirect.
  3. Otherwise: `instr <= mem[pc]`, `instr_pc <= pc`, `instr_valid <= 1`, `pc <= pc + 1`.
- **FETCH, `stall` high:** every register holds, including `instr` and `instr_valid`. `jump` and HALT are not evaluated.
- **`jump` with `instr_valid` low:** ignored.
- **PC arithmetic:** unsigned, modulo 2^ADDR_WIDTH. After address 2^ADDR_WIDTH−1 the next fetch is address 0. There is no error flag.
- **HALTED:** holds `instr`/`instr_pc` of the HALT word with `instr_valid` = 0. It is left only by `reset`.
- **Ignored inputs:** `start` and `prog_we` are ignored in FETCH and HALTED. Memory is never modified there.
- **Opcode handling:** opcodes 3'b000 and undefined values are fetched like any other instruction. Decoding them is the control unit's concern.

## Timing
- **Reset values:** state IDLE, `pc` 0, `instr` 0, `instr_pc` 0, `instr_valid` 0, `busy` 0, `halted` 0, so `control_opcode` is 0.
- **Reset and memory:** memory contents are not reset. A program survives `reset`.
- **Reset mid-operation:** synchronous reset takes effect at the next edge regardless of `stall`, `jump` or `start`. No write occurs that cycle even if `prog_we` is high.
- **Startup latency:** `start` sampled at edge N gives `instr_valid` = 1 with `instr_pc` = 0 after edge N+1.
- **Throughput:** one instruction per cycle with `stall` low and no redirect.
- **Redirect:** `jump` sampled at edge J gives `instr_valid` = 0 during cycle J..J+1. After edge J+1, `instr` = `mem[jump_target]`.
- **Halt:** a HALT word valid at edge H gives `halted` = 1 and `instr_valid` = 0 after edge H. No further memory reads.
- **Program write:** a write in IDLE is visible to a fetch starting the next cycle.

## Test plan
- **Straight-line fetch:**
  - Stimulus: reset; program `mem[0..3]` = 16'h8000, 16'hA001, 16'hC002, 16'hE000; pulse `start`.
  - Required: `instr_pc` 0,1,2,3 on consecutive cycles with `control_opcode` 100,101,110,111. The next cycle has `halted` = 1 and `instr_valid` = 0; both stay that way for 10 cycles.
- **Jump:**
  - Stimulus: `mem[2]` = 16'h6000 and `mem[9]` = 16'hE000; `jump` = 1, `jump_target` = 9 while `instr_pc` = 2.
  - Required: one cycle with `instr_valid` = 0; then `instr_pc` = 9 and `instr` = 16'hE000. Address 3 is never presented valid.
- **Stall:**
  - Stimulus: `stall` high for 3 cycles while `instr_pc` = 1.
  - Required: `instr`, `instr_pc` and `instr_valid` unchanged for 3 cycles. After release the next `instr_pc` is 2.
  - Also: `jump` asserted during the stall is ignored.
- **Wrap-around:**
  - Stimulus: `ADDR_WIDTH` = 3; program all 8 words non-HALT; start.
  - Required: `instr_pc` sequence 0..7,0,1.
- **Reset mid-run and ignored inputs:**
  - Stimulus: assert `reset` while fetching at PC 5.
  - Required: next cycle IDLE with all outputs at reset values. Restarting reproduces the original program.
  - Also: `prog_we` during FETCH leaves memory unchanged.
- **Halt then start:**
  - Stimulus: pulse `start` in HALTED.
  - Required: remains HALTED. Only `reset` followed by `start` resumes from PC 0.
